wys_1780_key_scan: RTL and testbench
====================================

# wys_1780_key_scan

Scans a 4x4 active-low matrix keypad, debounces one key at a time and assembles a three-digit decimal entry. It is the input-side counterpart of the four-digit multiplexed seven-segment display chain. The display chain drives column-rotated digit outputs; this block drives column-rotated keypad strobes and reads the rows back. `data2`/`data1`/`data0` connect directly to the display's digit data inputs, so typed digits appear on the display.

## Interface
- `SCAN_DIV`, 50000: `clk_in` cycles per scan tick; 1 kHz tick at 50 MHz; legal range ≥ 2.
- `DEB_CNT`, 20: consecutive scan ticks a press or release must persist; legal range ≥ 1.
- `clk_in` input 1: system clock; all state changes on the rising edge.
- `rst` input 1: asynchronous active-low reset; one clock, no other reset.
- `row` input 4: keypad rows, active-low, asynchronous to `clk_in`.
- `col` output 4: keypad column strobes, active-low one-hot.
- `key_code` output 4: code of the last accepted key, `row_idx*4 + col_idx`.
- `key_valid` output 1: one-cycle pulse when a key press is accepted.
- `pressed` output 1: high while an accepted key is held.
- `data2`, `data1`, `data0` output 4 each: entered digits, most significant first; each holds 0–9.

## Operation
- Row synchronizer: two flip-flops; all decisions use the synchronized `row_s`. Reset value is 4'hF.
- Tick divider:
  - Counts 0..SCAN_DIV-1 and wraps.
  - `tick` is high for one cycle when the count equals SCAN_DIV-1.
- Row decode:
  - `hit` = (`row_s` != 4'hF).
  - `row_idx` = lowest index with `row_s[i]` = 0; a lower row wins when several rows are low.
- `col_idx` is the index of the low bit of `col`.
- State machine, all transitions on `tick` only:
  - SCAN:
    - If `hit`: latch `cand` = {`row_idx`,`col_idx`}, clear `cnt`, go to DEBOUNCE, and hold `col`.
    - Otherwise rotate `col`: 1110→1101→1011→0111→1110.
  - DEBOUNCE (`col` frozen):
    - If `hit` and `row_idx` equals the latched row, increment `cnt`.
    - When `cnt` reaches DEB_CNT-1 on a qualifying tick: load `key_code` from `cand`, pulse `key_valid`, set `pressed`, and go to HOLD.
    - If not `hit`, or the row differs: go to SCAN with `col` unchanged; rotation resumes on the next tick.
  - HOLD (`col` frozen):
    - On a tick with no `hit`, increment `cnt`; on a tick with `hit`, clear `cnt`.
    - When `cnt` reaches DEB_CNT-1 on a no-hit tick: clear `pressed` and go to SCAN.
    - `cnt` is cleared on entry to HOLD.
- Digit entry, in the same cycle as `key_valid`:
  - Code 0–9: `data2`←`data1`, `data1`←`data0`, `data0`←code.
  - Code 12 (clear): all three digits go to 0.
  - Codes 10, 11, 13, 14, 15: `key_valid` still pulses; digits are unchanged.
- A second key pressed during HOLD is ignored. It can only be accepted after a full release debounce followed by a new press.
- Reset values:
  - `col`=4'b1110, `key_code`=0, `key_valid`=0, `pressed`=0, `data2..0`=0.
  - State SCAN; `cnt`, divider and synchronizer cleared (synchronizer to 4'hF).

## Timing
- `tick` period is exactly SCAN_DIV cycles. The first `tick` comes SCAN_DIV cycles after reset deassertion.
- Press-to-`key_valid`:
  - Detection happens on the first tick at which the driven column sees a low row, with ≥2 cycles of synchronizer latency before that tick.
  - `key_valid` then asserts DEB_CNT ticks later.
  - `key_valid` is registered: it is high in the cycle after the qualifying tick, for exactly one cycle.
- `pressed` rises in the same cycle as `key_valid`. It falls one cycle after the DEB_CNT-th consecutive no-hit tick in HOLD.
- `col` changes only in the cycle after a tick.
- A glitch shorter than one tick period is filtered unless it straddles a tick, and even then it cannot last DEB_CNT ticks.
- Reset asserted mid-DEBOUNCE or mid-HOLD: all outputs return to reset values immediately, asynchronously. No `key_valid` is emitted.

## Test plan
Bench parameters: SCAN_DIV=4, DEB_CNT=3.

- After reset, no key: `col` cycles 1110,1101,1011,0111 every 4 clocks; `key_valid` is never asserted; `data2..0`=0.
- Hold row1/col2 (code 6) low: exactly one `key_valid` pulse with `key_code`=6, `data0`=6; `pressed` stays high until 3 release ticks after letting go.
- Type 7, 8, 0 with full release between each: `data2`=7, `data1`=8, `data0`=0. Then press code 12: all three digits = 0.
- Row pulse 1 tick long: `col` freezes, then returns to SCAN; no `key_valid`; digits unchanged.
- Press code 5, then press code 9 while 5 is still held: only 5 is accepted. Release both for 3 ticks, re-press 9: `key_valid` with `key_code`=9.
- Assert `rst` during DEBOUNCE of code 3: outputs return to reset values immediately; no pulse. With the key still held after reset release, code 3 is accepted normally.

Source files
------------

// File: rtl/wys_1780_key_scan_if.sv
// Keypad and display-side signals of the key scanner.
// master = scanner, slave = keypad/display side.
interface wys_1780_key_scan_if;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       pressed;
    logic [3:0] data2;
    logic [3:0] data1;
    logic [3:0] data0;

    modport master (
        input  row,
        output col, key_code, key_valid, pressed, data2, data1, data0
    );

    modport slave (
        output row,
        input  col, key_code, key_valid, pressed, data2, data1, data0
    );
endinterface

// File: rtl/wys_1780_key_scan.sv
// 4x4 active-low keypad scanner with one-key debounce and three-digit decimal entry.
//
// state      | meaning
// S_SCAN     | rotating column strobe, waiting for a low row
// S_DEBOUNCE | column frozen, counting ticks the candidate row stays low
// S_HOLD     | key accepted, counting consecutive released ticks
module wys_1780_key_scan #(
    parameter int SCAN_DIV = 50000,
    parameter int DEB_CNT  = 20
) (
    input logic                 clk_in,
    input logic                 rst,
    wys_1780_key_scan_if.master kp
);
    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CNT - 1);

    typedef enum logic [1:0] {
        S_SCAN,
        S_DEBOUNCE,
        S_HOLD
    } state_t;

    logic [3:0]    row_m_q;
    logic [3:0]    row_s_q;
    logic [DW-1:0] div_q;
    logic [DW-1:0] div_d;
    logic          tick;
    logic          hit;
    logic [1:0]    row_idx;
    logic [1:0]    col_idx;

    state_t        state_q;
    logic [3:0]    col_q;
    logic [3:0]    cand_q;
    logic [CW-1:0] cnt_q;
    logic [3:0]    key_code_q;
    logic          key_valid_q;
    logic          pressed_q;
    logic [3:0]    data2_q;
    logic [3:0]    data1_q;
    logic [3:0]    data0_q;

    always_comb begin
        tick  = (div_q == DIV_LAST);
        div_d = tick ? '0 : div_q + 1'b1;
        hit   = (row_s_q != 4'hF);

        // Lowest low row wins when several rows are pulled down together.
        row_idx = 2'd0;
        if (!row_s_q[0])      row_idx = 2'd0;
        else if (!row_s_q[1]) row_idx = 2'd1;
        else if (!row_s_q[2]) row_idx = 2'd2;
        else if (!row_s_q[3]) row_idx = 2'd3;

        col_idx = 2'd0;
        case (col_q)
            4'b1101: col_idx = 2'd1;
            4'b1011: col_idx = 2'd2;
            4'b0111: col_idx = 2'd3;
            default: col_idx = 2'd0;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            row_m_q <= 4'hF;
            row_s_q <= 4'hF;
            div_q   <= '0;
        end else begin
            row_m_q <= kp.row;
            row_s_q <= row_m_q;
            div_q   <= div_d;
        end
    end

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state_q     <= S_SCAN;
            col_q       <= 4'b1110;
            cand_q      <= 4'd0;
            cnt_q       <= '0;
            key_code_q  <= 4'd0;
            key_valid_q <= 1'b0;
            pressed_q   <= 1'b0;
            data2_q     <= 4'd0;
            data1_q     <= 4'd0;
            data0_q     <= 4'd0;
        end else begin
            key_valid_q <= 1'b0;
            if (tick) begin
                case (state_q)
                    S_SCAN: begin
                        if (hit) begin
                            cand_q  <= {row_idx, col_idx};
                            cnt_q   <= '0;
                            state_q <= S_DEBOUNCE;
                        end else begin
                            col_q <= {col_q[2:0], col_q[3]};
                        end
                    end
                    S_DEBOUNCE: begin
                        if (hit && (row_idx == cand_q[3:2])) begin
                            if (cnt_q == CNT_LAST) begin
                                key_code_q  <= cand_q;
                                key_valid_q <= 1'b1;
                                pressed_q   <= 1'b1;
                                cnt_q       <= '0;
                                state_q     <= S_HOLD;
                                if (cand_q < 4'd10) begin
                                    data2_q <= data1_q;
                                    data1_q <= data0_q;
                                    data0_q <= cand_q;
                                end else if (cand_q == 4'd12) begin
                                    data2_q <= 4'd0;
                                    data1_q <= 4'd0;
                                    data0_q <= 4'd0;
                                end
                            end else begin
                                cnt_q <= cnt_q + 1'b1;
                            end
                        end else begin
                            state_q <= S_SCAN;
                        end
                    end
                    S_HOLD: begin
                        // Any low row on the frozen column restarts the release count.
                        if (hit) begin
                            cnt_q <= '0;
                        end else if (cnt_q == CNT_LAST) begin
                            pressed_q <= 1'b0;
                            state_q   <= S_SCAN;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    default: state_q <= S_SCAN;
                endcase
            end
        end
    end

    assign kp.col       = col_q;
    assign kp.key_code  = key_code_q;
    assign kp.key_valid = key_valid_q;
    assign kp.pressed   = pressed_q;
    assign kp.data2     = data2_q;
    assign kp.data1     = data1_q;
    assign kp.data0     = data0_q;
endmodule

// File: tb/tb_wys_1780_key_scan.sv
// Bench for wys_1780_key_scan: a keypad matrix model drives the rows, and a
// tick-level behavioural model predicts every output on every cycle.
module tb_wys_1780_key_scan;
    localparam int SCAN_DIV = 4;
    localparam int DEB_CNT  = 3;
    localparam int M_SCAN = 0, M_DEB = 1, M_HOLD = 2;

    logic        clk_in = 1'b0;
    logic        rst    = 1'b0;
    logic [15:0] keys   = 16'h0000;
    int          checks  = 0;
    int          errors  = 0;
    int          kv_seen = 0;

    wys_1780_key_scan_if kif ();

    wys_1780_key_scan #(
        .SCAN_DIV(SCAN_DIV),
        .DEB_CNT (DEB_CNT)
    ) dut (
        .clk_in(clk_in),
        .rst   (rst),
        .kp    (kif)
    );

    always #5 clk_in = ~clk_in;

    // Physical keypad: a held key at (r,c) pulls row r low while column c is strobed.
    function automatic logic [3:0] pad(input logic [3:0] cv, input logic [15:0] k);
        logic [3:0] r;
        r = 4'hF;
        for (int rr = 0; rr < 4; rr++)
            for (int cc = 0; cc < 4; cc++)
                if (k[rr*4+cc] && !cv[cc]) r[rr] = 1'b0;
        return r;
    endfunction

    function automatic int low_row(input logic [3:0] r);
        for (int i = 0; i < 4; i++)
            if (!r[i]) return i;
        return -1;
    endfunction

    function automatic logic [3:0] colv(input int ci);
        return 4'b1111 ^ (4'b0001 << ci);
    endfunction

    always_comb kif.row = pad(kif.col, keys);

    // Reference model: column index, run lengths of qualifying ticks, digit register.
    int         m_cyc = 0, m_ci = 0, m_mode = M_SCAN, m_run = 0, m_row = 0;
    logic [3:0] m_s1 = 4'hF, m_s2 = 4'hF;
    logic [3:0] m_kc = 4'd0, m_d2 = 4'd0, m_d1 = 4'd0, m_d0 = 4'd0;
    logic       m_kv = 1'b0, m_pr = 1'b0;

    always @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            m_s1 <= 4'hF; m_s2 <= 4'hF; m_cyc <= 0; m_ci <= 0; m_mode <= M_SCAN;
            m_run <= 0; m_row <= 0; m_kc <= 4'd0; m_kv <= 1'b0; m_pr <= 1'b0;
            m_d2 <= 4'd0; m_d1 <= 4'd0; m_d0 <= 4'd0;
        end else begin
            m_s1  <= pad(colv(m_ci), keys);
            m_s2  <= m_s1;
            m_cyc <= m_cyc + 1;
            m_kv  <= 1'b0;
            if (m_cyc % SCAN_DIV == SCAN_DIV - 1) begin
                if (m_mode == M_SCAN) begin
                    if (low_row(m_s2) >= 0) begin
                        m_row <= low_row(m_s2); m_run <= 0; m_mode <= M_DEB;
                    end else begin
                        m_ci <= (m_ci + 1) % 4;
                    end
                end else if (m_mode == M_DEB) begin
                    if (low_row(m_s2) != m_row) m_mode <= M_SCAN;
                    else if (m_run + 1 < DEB_CNT) m_run <= m_run + 1;
                    else begin
                        m_kc <= 4'(m_row * 4 + m_ci);
                        m_kv <= 1'b1; m_pr <= 1'b1; m_mode <= M_HOLD; m_run <= 0;
                        if (m_row * 4 + m_ci < 10) begin
                            m_d2 <= m_d1; m_d1 <= m_d0; m_d0 <= 4'(m_row * 4 + m_ci);
                        end else if (m_row * 4 + m_ci == 12) begin
                            m_d2 <= 4'd0; m_d1 <= 4'd0; m_d0 <= 4'd0;
                        end
                    end
                end else begin
                    if (low_row(m_s2) >= 0) m_run <= 0;
                    else if (m_run + 1 < DEB_CNT) m_run <= m_run + 1;
                    else begin m_pr <= 1'b0; m_mode <= M_SCAN; end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk_in) begin
        chk("col", 32'(kif.col), 32'(colv(m_ci)));
        chk("key_code", 32'(kif.key_code), 32'(m_kc));
        chk("key_valid", 32'(kif.key_valid), 32'(m_kv));
        chk("pressed", 32'(kif.pressed), 32'(m_pr));
        chk("data2", 32'(kif.data2), 32'(m_d2));
        chk("data1", 32'(kif.data1), 32'(m_d1));
        chk("data0", 32'(kif.data0), 32'(m_d0));
        if (kif.key_valid === 1'b1) kv_seen++;
    end

    task automatic wait_kv(input int budget, input string name);
        int n;
        n = 0;
        while (kif.key_valid !== 1'b1 && n < budget) begin
            @(negedge clk_in);
            n++;
        end
        chk({name, "_kv_timeout"}, 32'(n < budget), 32'd1);
    endtask

    task automatic wait_release(input int budget, output int n);
        n = 0;
        while (kif.pressed === 1'b1 && n < budget) begin
            @(negedge clk_in);
            n++;
        end
        chk("release_timeout", 32'(n < budget), 32'd1);
    endtask

    task automatic type_key(input int code);
        int n;
        keys = 16'(1 << code);
        wait_kv(200, "type");
        chk("type_code", 32'(kif.key_code), 32'(code));
        keys = 16'h0000;
        wait_release(200, n);
        repeat (8) @(negedge clk_in);
    endtask

    initial begin
        int n, kv0, c, budget;
        rst = 1'b0;
        repeat (3) @(negedge clk_in);
        rst = 1'b1;
        @(negedge clk_in);
        chk("reset_col", 32'(kif.col), 32'h0000_000E);
        chk("reset_data", {20'd0, kif.data2, kif.data1, kif.data0}, 32'd0);

        // Idle: no key, no pulse, rotating columns checked by the model.
        kv0 = kv_seen;
        repeat (40) @(negedge clk_in);
        chk("idle_no_kv", 32'(kv_seen - kv0), 32'd0);

        // Code 6 held: single acceptance, release after three quiet ticks.
        kv0 = kv_seen;
        keys = 16'(1 << 6);
        wait_kv(200, "k6");
        chk("k6_code", 32'(kif.key_code), 32'd6);
        chk("k6_data0", 32'(kif.data0), 32'd6);
        chk("k6_pressed", 32'(kif.pressed), 32'd1);
        repeat (30) @(negedge clk_in);
        chk("k6_still_pressed", 32'(kif.pressed), 32'd1);
        keys = 16'h0000;
        wait_release(200, n);
        chk("k6_release_delay", 32'(n >= 11 && n <= 14), 32'd1);
        chk("k6_one_pulse", 32'(kv_seen - kv0), 32'd1);
        repeat (8) @(negedge clk_in);

        type_key(7);
        type_key(8);
        type_key(0);
        chk("entry_780", {20'd0, kif.data2, kif.data1, kif.data0}, 32'h0000_0780);
        type_key(12);
        chk("clear_digits", {20'd0, kif.data2, kif.data1, kif.data0}, 32'd0);
        chk("clear_code", 32'(kif.key_code), 32'd12);

        // One-tick row pulse right after a column change: freeze, back to scan, no pulse.
        budget = 0;
        while (!((m_cyc % SCAN_DIV) == 0 && m_mode == M_SCAN) && budget < 100) begin
            @(negedge clk_in);
            budget++;
        end
        c = m_ci;
        kv0 = kv_seen;
        keys = 16'(1 << (8 + c));
        repeat (4) @(negedge clk_in);
        keys = 16'h0000;
        repeat (7) @(negedge clk_in);
        chk("glitch_col_frozen", 32'(kif.col), 32'(colv(c)));
        repeat (2) @(negedge clk_in);
        chk("glitch_col_resumed", 32'(kif.col), 32'(colv((c + 1) % 4)));
        repeat (8) @(negedge clk_in);
        chk("glitch_no_kv", 32'(kv_seen - kv0), 32'd0);
        chk("glitch_digits", {20'd0, kif.data2, kif.data1, kif.data0}, 32'd0);

        // Code 5 held, code 9 added on the same column: only 5 accepted.
        kv0 = kv_seen;
        keys = 16'(1 << 5);
        wait_kv(200, "k5");
        chk("k5_code", 32'(kif.key_code), 32'd5);
        repeat (8) @(negedge clk_in);
        keys = 16'(1 << 5) | 16'(1 << 9);
        repeat (40) @(negedge clk_in);
        chk("k9_ignored", 32'(kv_seen - kv0), 32'd1);
        keys = 16'h0000;
        wait_release(200, n);
        repeat (4) @(negedge clk_in);
        keys = 16'(1 << 9);
        wait_kv(200, "k9");
        chk("k9_code", 32'(kif.key_code), 32'd9);
        chk("k9_digits", {20'd0, kif.data2, kif.data1, kif.data0}, 32'h0000_0059);
        keys = 16'h0000;
        wait_release(200, n);
        repeat (8) @(negedge clk_in);

        // Reset in the middle of debouncing code 3, key kept held.
        kv0 = kv_seen;
        keys = 16'(1 << 3);
        budget = 0;
        while (m_mode != M_DEB && budget < 200) begin
            @(negedge clk_in);
            budget++;
        end
        @(negedge clk_in);
        #2 rst = 1'b0;
        #1;
        chk("rst_col", 32'(kif.col), 32'h0000_000E);
        chk("rst_code", 32'(kif.key_code), 32'd0);
        chk("rst_kv", 32'(kif.key_valid), 32'd0);
        chk("rst_pressed", 32'(kif.pressed), 32'd0);
        chk("rst_digits", {20'd0, kif.data2, kif.data1, kif.data0}, 32'd0);
        repeat (3) @(negedge clk_in);
        chk("rst_no_kv", 32'(kv_seen - kv0), 32'd0);
        rst = 1'b1;
        wait_kv(200, "k3");
        chk("k3_code", 32'(kif.key_code), 32'd3);
        chk("k3_digits", {20'd0, kif.data2, kif.data1, kif.data0}, 32'd3);
        keys = 16'h0000;
        wait_release(200, n);
        repeat (8) @(negedge clk_in);

        // Random presses, chords and short taps against the model.
        for (int it = 0; it < 40; it++) begin
            keys = 16'(1 << $urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) keys = keys | 16'(1 << $urandom_range(0, 15));
            repeat ($urandom_range(1, 90)) @(negedge clk_in);
            keys = 16'h0000;
            repeat ($urandom_range(1, 70)) @(negedge clk_in);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end
endmodule
